// File: rtl/rc4_decrypt_ctrl_if.sv
// Handshake/bus bundle for rc4_decrypt_ctrl: command, ciphertext in, plaintext out,
// keystream-generator control and status.
interface rc4_decrypt_ctrl_if #(parameter int LEN_W = 16);
  logic             start_i;
  logic             abort_i;
  logic [31:0]      key_i;
  logic [LEN_W-1:0] byte_count_i;
  logic             cipher_valid_i;
  logic [7:0]       cipher_data_i;
  logic             cipher_ready_o;
  logic             plain_valid_o;
  logic [7:0]       plain_data_o;
  logic             plain_ready_i;
  logic [31:0]      rc4_key_o;
  logic             genStateArr_o;
  logic             genVal_o;
  logic             sarrGenerated_i;
  logic             valReady_i;
  logic [7:0]       keystream_i;
  logic             busy_o;
  logic             done_o;

  modport slave (
    input  start_i, abort_i, key_i, byte_count_i,
    input  cipher_valid_i, cipher_data_i, plain_ready_i,
    input  sarrGenerated_i, valReady_i, keystream_i,
    output cipher_ready_o, plain_valid_o, plain_data_o,
    output rc4_key_o, genStateArr_o, genVal_o, busy_o, done_o
  );

  modport master (
    output start_i, abort_i, key_i, byte_count_i,
    output cipher_valid_i, cipher_data_i, plain_ready_i,
    output sarrGenerated_i, valReady_i, keystream_i,
    input  cipher_ready_o, plain_valid_o, plain_data_o,
    input  rc4_key_o, genStateArr_o, genVal_o, busy_o, done_o
  );
endinterface

// File: rtl/rc4_decrypt_ctrl.sv
// RC4 decrypt sequencer: key setup, optional keystream drop (macro RC4_DROP_EN),
// then one fetch / keystream / XOR / output round per ciphertext byte.
module rc4_decrypt_ctrl #(
  parameter int LEN_W      = 16,
  parameter int DROP_COUNT = 256
) (
  input  logic            clk,
  input  logic            rst,
  rc4_decrypt_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    KEYGEN,
`ifdef RC4_DROP_EN
    DROP,
`endif
    FETCH,
    WAIT,
    OUT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      key_q;
  logic [LEN_W-1:0] rem_q;
  logic [7:0]       cipher_q;
  logic [7:0]       pdata_q;
  logic             pvalid_q;
  logic             req_q;     // keystream request outstanding, blocks re-pulse of genVal_o
  logic             in_req;
  logic             gen_val;
  logic             val_hit;
  logic             cipher_ready;
  logic             cipher_hs;
  logic             plain_hs;

`ifdef RC4_DROP_EN
  localparam int DROP_W = (DROP_COUNT > 1) ? $clog2(DROP_COUNT) : 1;
  logic [DROP_W-1:0] drop_cnt_q;
  logic              drop_last;
  assign drop_last = (drop_cnt_q == DROP_W'(DROP_COUNT - 1));
`endif

  always_comb begin
    in_req = (state_q == WAIT);
`ifdef RC4_DROP_EN
    if (state_q == DROP) in_req = 1'b1;
`endif
  end

  assign cipher_ready = (state_q == FETCH) && !bus.abort_i;
  assign cipher_hs    = cipher_ready && bus.cipher_valid_i;
  assign gen_val      = in_req && !req_q && !bus.abort_i;
  assign val_hit      = in_req && bus.valReady_i;
  assign plain_hs     = (state_q == OUT) && pvalid_q && bus.plain_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.start_i)
                state_d = (bus.byte_count_i == '0) ? DONE : KEYGEN;
`ifdef RC4_DROP_EN
      KEYGEN: if (bus.sarrGenerated_i) state_d = DROP;
      DROP:   if (val_hit && drop_last) state_d = FETCH;
`else
      KEYGEN: if (bus.sarrGenerated_i) state_d = FETCH;
`endif
      FETCH:  if (cipher_hs) state_d = WAIT;
      WAIT:   if (val_hit) state_d = OUT;
      OUT:    if (plain_hs)
                state_d = (rem_q <= LEN_W'(1)) ? DONE : FETCH;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort_i) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q    <= '0;
      rem_q    <= '0;
      cipher_q <= '0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
      req_q    <= 1'b0;
    end else if (bus.abort_i) begin
      pvalid_q <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.start_i) begin
        key_q <= bus.key_i;
        rem_q <= bus.byte_count_i;
      end
      if (gen_val) req_q <= 1'b1;
      if (val_hit) req_q <= 1'b0;
      if (cipher_hs) cipher_q <= bus.cipher_data_i;
      if (state_q == WAIT && bus.valReady_i) begin
        pdata_q  <= cipher_q ^ bus.keystream_i;
        pvalid_q <= 1'b1;
      end
      if (plain_hs) begin
        pvalid_q <= 1'b0;
        if (rem_q != '0) rem_q <= rem_q - LEN_W'(1);
      end
    end
  end

`ifdef RC4_DROP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            drop_cnt_q <= '0;
    else if (bus.abort_i)               drop_cnt_q <= '0;
    else if (state_q == DROP && val_hit) drop_cnt_q <= drop_last ? '0 : drop_cnt_q + DROP_W'(1);
  end
`endif

  assign bus.cipher_ready_o = cipher_ready;
  assign bus.plain_valid_o  = pvalid_q;
  assign bus.plain_data_o   = pdata_q;
  assign bus.rc4_key_o      = key_q;
  assign bus.genStateArr_o  = (state_q == KEYGEN);
  assign bus.genVal_o       = gen_val;
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.done_o         = (state_q == DONE) && !bus.abort_i;

endmodule

// File: doc/rc4_decrypt_ctrl.md
RC4_DECRYPT_CTRL -- requirements
Module: rc4_decrypt_ctrl

Interface
- REQ-001: The block SHALL have parameter LEN_W, default 16, giving the width of the byte-count and remaining counter.
- REQ-002: The block SHALL have parameter DROP_COUNT, default 256, giving the number of keystream bytes discarded (used only under RC4_DROP_EN).
- REQ-003: The ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-high reset
  start_i  in  1  begin an operation; sampled only in IDLE
  abort_i  in  1  synchronous abort to IDLE
  key_i  in  32  RC4 key, sampled with start_i
  byte_count_i  in  LEN_W  bytes to decrypt, sampled with start_i
  cipher_valid_i  in  1  ciphertext byte valid
  cipher_data_i  in  8  ciphertext byte
  cipher_ready_o  out  1  controller accepts ciphertext
  plain_valid_o  out  1  plaintext byte valid
  plain_data_o  out  8  plaintext byte
  plain_ready_i  in  1  sink accepts plaintext
  rc4_key_o  out  32  latched key to generator
  genStateArr_o  out  1  request state-array generation
  genVal_o  out  1  request one keystream byte (1-cycle pulse)
  sarrGenerated_i  in  1  generator: state array done
  valReady_i  in  1  generator: keystream byte valid
  keystream_i  in  8  generator keystream byte
  busy_o  out  1  high in every state except IDLE
  done_o  out  1  1-cycle pulse at operation completion

Function
- REQ-004: The FSM SHALL have the states IDLE, KEYGEN, DROP, FETCH, WAIT, OUT and DONE.
- REQ-005: In IDLE, start_i=1 SHALL latch key_i into rc4_key_o and byte_count_i into the remaining counter; the next state SHALL be KEYGEN, or DONE if byte_count_i=0.
- REQ-006: start_i SHALL be ignored outside IDLE; rc4_key_o SHALL hold stable until the next accepted start_i.
- REQ-007: genStateArr_o SHALL be high for every KEYGEN cycle; sarrGenerated_i=1 SHALL move the FSM to DROP (macro defined) or FETCH.
- REQ-008: In FETCH, cipher_ready_o=1; on cipher_valid_i&cipher_ready_o the byte SHALL be registered and the FSM SHALL move to WAIT.
- REQ-009: genVal_o SHALL pulse for exactly the first cycle of each WAIT or DROP byte request; it SHALL not re-pulse until valReady_i returns.
- REQ-010: In WAIT, valReady_i=1 SHALL register plain_data_o = cipher byte XOR keystream_i, set plain_valid_o=1 on the next cycle, and move the FSM to OUT.
- REQ-011: In OUT, plain_valid_o and plain_data_o SHALL hold stable until plain_ready_i=1; on that handshake the remaining counter SHALL decrement.
- REQ-012: After the OUT handshake, the next state SHALL be DONE if remaining reaches 0, else FETCH.
- REQ-013: DONE SHALL assert done_o for one cycle and return to IDLE.
- REQ-014: valReady_i SHALL be ignored outside WAIT and DROP.
- REQ-015: cipher_ready_o SHALL be 0 outside FETCH.
- REQ-016: abort_i=1 SHALL force IDLE on the next edge from any state and deassert all handshake outputs; done_o SHALL not pulse.
- REQ-017: abort_i SHALL take priority over start_i in the same cycle.
- REQ-018: The remaining counter SHALL never wrap below 0.
- REQ-019: byte_count_i of all ones SHALL be processed in full.

Reset
- REQ-020: rst=1 SHALL asynchronously force IDLE and clear all outputs, rc4_key_o, plain_data_o, the counters and the registered cipher byte to 0.
- REQ-021: Reset asserted mid-operation SHALL abandon the operation without a done_o pulse.

Configuration
- REQ-022: With macro RC4_DROP_EN defined, DROP SHALL request and discard DROP_COUNT keystream bytes (one genVal_o per valReady_i) before entering FETCH; cipher_ready_o SHALL stay 0 throughout.
- REQ-023: Without RC4_DROP_EN, the DROP state and its counter SHALL be absent and KEYGEN SHALL go directly to FETCH.

Verification
- REQ-024: Key 0x01020304, count 3, ciphertext 0xAA,0x55,0xFF, keystream 0x0F,0xF0,0x00 -> plaintext 0xA5,0xA5,0xFF, then one done_o pulse.
- REQ-025: start_i with byte_count_i=0 -> DONE on the next cycle; genStateArr_o never asserted; done_o pulses once.
- REQ-026: plain_ready_i held 0 for 5 cycles in OUT -> plain_data_o and plain_valid_o stable; no cipher_ready_o; remaining unchanged.
- REQ-027: abort_i asserted in WAIT -> IDLE next cycle, busy_o=0, no done_o; a subsequent start_i is accepted normally.
- REQ-028: RC4_DROP_EN with DROP_COUNT=256 -> exactly 256 genVal_o pulses before the first cipher_ready_o.
- REQ-029: rst asserted mid-FETCH -> all outputs 0 immediately, without waiting for a clock edge.
